// File: rtl/daq_adc_reader.sv
// daq_adc_reader: after the ADC drops BUSY, reads NUM_CHANNELS parallel words
// with cs_n/rd_n strobes and hands each word to the datapath as a one-cycle
// valid beat tagged with its channel index. A conversion that restarts
// mid-readout aborts the frame and raises a sticky overrun flag.
module daq_adc_reader #(
  parameter int NUM_CHANNELS   = 8,
  parameter int DATA_W         = 16,
  parameter int RD_LOW_CYCLES  = 2,
  parameter int RD_HIGH_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              en_i,
  input  logic              busy_i,
  input  logic [DATA_W-1:0] db_i,
  input  logic              clr_overrun_i,
  output logic              cs_n_o,
  output logic              rd_n_o,
  output logic [DATA_W-1:0] sample_o,
  output logic [3:0]        chan_o,
  output logic              valid_o,
  output logic              frame_done_o,
  output logic              overrun_o,
  output logic [15:0]       frame_count_o
);

  localparam int CYC_MAX = (RD_LOW_CYCLES > RD_HIGH_CYCLES) ? RD_LOW_CYCLES : RD_HIGH_CYCLES;
  localparam int CNT_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam logic [CNT_W-1:0] LO_LAST = CNT_W'(RD_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] HI_LAST = CNT_W'(RD_HIGH_CYCLES - 1);
  localparam logic [3:0]       CH_LAST = 4'(NUM_CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, CS_SETUP, RD_LO, RD_HI} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cyc_reg, cyc_next;
  logic [3:0]          chan_cnt_reg, chan_cnt_next;
  logic                busy_meta_reg, busy_sync_reg, busy_prev_reg;
  logic                cs_n_reg, cs_n_next;
  logic                rd_n_reg, rd_n_next;
  logic [DATA_W-1:0]   sample_reg, sample_next;
  logic [3:0]          chan_reg, chan_next;
  logic                valid_reg, valid_next;
  logic                done_reg, done_next;
  logic                overrun_reg, overrun_next;
  logic [15:0]         frame_count_reg;
  logic                frame_inc;
  logic                set_overrun;
  logic                busy_fall, busy_rise;

  // Sync regs come out of reset high so releasing reset never looks like a BUSY fall.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      busy_meta_reg <= 1'b1;
      busy_sync_reg <= 1'b1;
      busy_prev_reg <= 1'b1;
    end else begin
      busy_meta_reg <= busy_i;
      busy_sync_reg <= busy_meta_reg;
      busy_prev_reg <= busy_sync_reg;
    end
  end

  assign busy_fall = busy_prev_reg & ~busy_sync_reg;
  assign busy_rise = ~busy_prev_reg & busy_sync_reg;

  // State, counters and all registered outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg    <= IDLE;
      cyc_reg      <= '0;
      chan_cnt_reg <= '0;
      cs_n_reg     <= 1'b1;
      rd_n_reg     <= 1'b1;
      sample_reg   <= '0;
      chan_reg     <= '0;
      valid_reg    <= 1'b0;
      done_reg     <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cyc_reg      <= cyc_next;
      chan_cnt_reg <= chan_cnt_next;
      cs_n_reg     <= cs_n_next;
      rd_n_reg     <= rd_n_next;
      sample_reg   <= sample_next;
      chan_reg     <= chan_next;
      valid_reg    <= valid_next;
      done_reg     <= done_next;
      overrun_reg  <= overrun_next;
    end
  end

  // Frame counter only loads on completion; otherwise it holds its value.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      frame_count_reg <= '0;
    end else if (frame_inc) begin
      frame_count_reg <= frame_count_reg + 16'd1;
    end
  end

  // Next-state logic; an overrun abort takes priority over normal sequencing.
  always_comb begin
    state_next    = state_reg;
    cyc_next      = cyc_reg;
    chan_cnt_next = chan_cnt_reg;
    sample_next   = sample_reg;
    chan_next     = chan_reg;
    valid_next    = 1'b0;
    done_next     = 1'b0;
    frame_inc     = 1'b0;
    set_overrun   = 1'b0;

    if (busy_rise && (state_reg != IDLE)) begin
      set_overrun = 1'b1;
      state_next  = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (busy_fall && en_i) state_next = CS_SETUP;
        end
        CS_SETUP: begin
          state_next    = RD_LO;
          cyc_next      = '0;
          chan_cnt_next = '0;
        end
        RD_LO: begin
          if (cyc_reg == LO_LAST) begin
            sample_next = db_i;
            chan_next   = chan_cnt_reg;
            valid_next  = 1'b1;
            cyc_next    = '0;
            state_next  = RD_HI;
          end else begin
            cyc_next = cyc_reg + CNT_W'(1);
          end
        end
        RD_HI: begin
          if (cyc_reg == HI_LAST) begin
            cyc_next = '0;
            if (chan_cnt_reg == CH_LAST) begin
              state_next = IDLE;
              done_next  = 1'b1;
              frame_inc  = 1'b1;
            end else begin
              chan_cnt_next = chan_cnt_reg + 4'd1;
              state_next    = RD_LO;
            end
          end else begin
            cyc_next = cyc_reg + CNT_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end

    // Strobes are decoded from the next state so they change on the same edge as the state.
    cs_n_next = (state_next == IDLE);
    rd_n_next = (state_next != RD_LO);

    // A coincident set beats the clear.
    if (set_overrun)        overrun_next = 1'b1;
    else if (clr_overrun_i) overrun_next = 1'b0;
    else                    overrun_next = overrun_reg;
  end

  assign cs_n_o        = cs_n_reg;
  assign rd_n_o        = rd_n_reg;
  assign sample_o      = sample_reg;
  assign chan_o        = chan_reg;
  assign valid_o       = valid_reg;
  assign frame_done_o  = done_reg;
  assign overrun_o     = overrun_reg;
  assign frame_count_o = frame_count_reg;

endmodule

// File: doc/daq_adc_reader.md
Name: daq_adc_reader

Overview:
- Readback side of the ADC conversion handshake. The trigger controller pulses the converter start; this block is what happens afterwards.
- Watches busy_i. When busy falls, it reads NUM_CHANNELS parallel words from the ADC by driving cs_n_o and rd_n_o strobes.
- Presents each word with its channel index as a one-cycle valid beat to the DAQ datapath.
- Flags an overrun if a new conversion starts before the readout finishes.

Parameters:
- NUM_CHANNELS, 8, words read per conversion frame (1..16).
- DATA_W, 16, ADC parallel bus width.
- RD_LOW_CYCLES, 2, clk_i cycles rd_n_o is held low per word (>=1).
- RD_HIGH_CYCLES, 2, clk_i cycles rd_n_o is held high between words (>=1).

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  asynchronous active-high reset.
- en_i  in  1  synchronous enable; 0 blocks new frames.
- busy_i  in  1  ADC BUSY, asynchronous to clk_i.
- db_i  in  DATA_W  ADC parallel data bus.
- clr_overrun_i  in  1  synchronous clear of overrun_o.
- cs_n_o  out  1  ADC chip select, active low.
- rd_n_o  out  1  ADC read strobe, active low.
- sample_o  out  DATA_W  captured word.
- chan_o  out  4  channel index of sample_o (0-based).
- valid_o  out  1  one-cycle qualifier for sample_o/chan_o.
- frame_done_o  out  1  one-cycle pulse after the last word of a frame.
- overrun_o  out  1  sticky overrun flag.
- frame_count_o  out  16  completed frames; wraps 0xFFFF->0.

Behaviour:
- Reset (async, any state): state IDLE; cs_n_o=1; rd_n_o=1; valid_o=0; frame_done_o=0; overrun_o=0; sample_o=0; chan_o=0; frame_count_o=0.
- Synchronizers reset to 1 (busy-idle-high assumption is forbidden; sync regs reset high so no false fall at reset release).
- All outputs are registered.
- busy_i passes through a 2-flop synchronizer. fall = prev_sync & ~sync; rise = ~prev_sync & sync.
- States:
  - IDLE: on fall & en_i -> CS_SETUP. cs_n_o goes low 2 cycles after the edge that first samples busy_i low.
  - CS_SETUP: 1 cycle, cs_n_o=0, rd_n_o=1 -> RD_LO. Channel counter = 0.
  - RD_LO: rd_n_o=0 for RD_LOW_CYCLES cycles. On the last cycle's edge: capture db_i into sample_o, load chan_o from the channel counter, set valid_o=1 for exactly 1 cycle, and rd_n_o returns to 1 -> RD_HI.
  - RD_HI: rd_n_o=1 for RD_HIGH_CYCLES cycles, then:
    - if channel < NUM_CHANNELS-1: increment channel -> RD_LO.
    - else: cs_n_o=1, frame_done_o=1 (1 cycle), frame_count_o+1 -> IDLE.
- Frame length from cs_n_o fall to frame_done_o: 1 + NUM_CHANNELS*(RD_LOW_CYCLES+RD_HIGH_CYCLES) cycles.
- en_i deasserted mid-frame: the current frame completes normally; only new starts are blocked.
- Overrun: if rise occurs in any state other than IDLE:
  - set overrun_o;
  - abort: next cycle cs_n_o=1, rd_n_o=1, state IDLE;
  - no frame_done_o, frame_count_o unchanged;
  - an in-flight valid_o already issued stands; no further valid_o beats.
- Overrun and fall are never simultaneous (sync is monotonic per cycle).
- clr_overrun_i clears overrun_o. If set and clear coincide, set wins.
- Falls while not IDLE (only possible after an abort) are ignored.
- No backpressure: the consumer must accept every valid_o beat.

Test Plan:
- Defaults, db_i = 0x1000+channel per rd strobe; single busy_i low pulse. Required response:
  - 8 valid_o beats with chan_o 0..7 and sample_o 0x1000..0x1007;
  - valid_o beats spaced 4 cycles apart;
  - frame_done_o 33 cycles after cs_n_o falls;
  - frame_count_o=1.
- Assert reset_i mid-frame at channel 3 -> cs_n_o and rd_n_o go to 1 immediately (async); all outputs at reset values; next busy fall starts a clean frame from channel 0.
- busy_i rises during channel 5 -> overrun_o=1; cs_n_o high next cycle; only 6 valid_o beats; frame_count_o unchanged. Then pulse clr_overrun_i -> overrun_o=0.
- en_i=0 when busy falls -> no cs_n_o activity. en_i dropped at channel 2 -> frame finishes all 8 words and frame_done_o pulses.
- NUM_CHANNELS=1, RD_LOW_CYCLES=1, RD_HIGH_CYCLES=1 -> exactly 1 valid_o beat; frame_done_o 3 cycles after cs_n_o falls.
- Preload frame_count_o to 0xFFFF (65535 frames or forced) -> next frame wraps it to 0x0000.
